// File: rtl/dsm_sample_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : dsm_sample_sequencer
// Description : Holds each accepted sample on the delta-sigma alpha input for
//               an oversampling window and reports the count of MSB ones.
// Revision    : 1.0 - initial release
// ============================================================================
module dsm_sample_sequencer #(
    parameter int WIDTH = 16,
    parameter int OSR_W = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [OSR_W-1:0] cfg_osr,
    input  logic             cfg_clr_en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] alpha,
    output logic             dsm_clr,
    input  logic             dsm_msb,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [OSR_W-1:0] res_count,
    output logic             busy
);

    localparam logic [1:0] c_s_idle   = 2'd0;
    localparam logic [1:0] c_s_clear  = 2'd1;
    localparam logic [1:0] c_s_run    = 2'd2;
    localparam logic [1:0] c_s_report = 2'd3;

    localparam logic [OSR_W-1:0] c_one = OSR_W'(1);

    logic [1:0]       r_state;
    logic [1:0]       w_next;
    logic [WIDTH-1:0] r_alpha;
    logic [OSR_W-1:0] r_osr;
    logic [OSR_W-1:0] r_ones;
    logic [OSR_W-1:0] r_cyc;
    logic [OSR_W-1:0] r_count;
    logic [OSR_W-1:0] w_msb_ext;
    logic             w_capture;
    logic             w_last;

    assign w_msb_ext = {{(OSR_W-1){1'b0}}, dsm_msb};
    assign w_capture = (r_state == c_s_idle) && in_valid;
    assign w_last    = (r_cyc == (r_osr - c_one));

    // Handshake outputs decode state only, so no input reaches them combinationally.
    assign in_ready  = (r_state == c_s_idle);
    assign dsm_clr   = (r_state == c_s_clear);
    assign res_valid = (r_state == c_s_report);
    assign busy      = (r_state != c_s_idle);
    assign alpha     = r_alpha;
    assign res_count = r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_s_idle;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_s_idle:   if (in_valid) w_next = cfg_clr_en ? c_s_clear : c_s_run;
            c_s_clear:  w_next = c_s_run;
            c_s_run:    if (w_last) w_next = c_s_report;
            c_s_report: if (res_ready) w_next = c_s_idle;
            default:    w_next = c_s_idle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_alpha <= '0;
            r_osr   <= c_one;
            r_ones  <= '0;
            r_cyc   <= '0;
            r_count <= '0;
        end else if (w_capture) begin
            r_alpha <= in_data;
            r_osr   <= (cfg_osr == '0) ? c_one : cfg_osr;
            r_ones  <= '0;
            r_cyc   <= '0;
        end else if (r_state == c_s_run) begin
            r_ones <= r_ones + w_msb_ext;
            r_cyc  <= r_cyc + c_one;
            // Final edge folds the current MSB in directly; ones never exceeds osr.
            if (w_last) begin
                r_count <= r_ones + w_msb_ext;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dsm_sample_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_dsm_sample_sequencer
// Description : Self-checking bench for dsm_sample_sequencer with a reference
//               window model and a behavioural first-order modulator.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dsm_sample_sequencer;

    logic        clk;
    logic        reset;
    logic [9:0]  cfg_osr;
    logic        cfg_clr_en;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [15:0] alpha;
    logic        dsm_clr;
    logic        dsm_msb;
    logic        res_valid;
    logic        res_ready;
    logic [9:0]  res_count;
    logic        busy;

    int errors = 0;
    int checks = 0;

    int          pat [0:1023];
    logic        pat_msb;
    logic        use_dsm;
    logic [15:0] dsm_acc;
    logic [16:0] dsm_sum;

    dsm_sample_sequencer #(.WIDTH(16), .OSR_W(10)) dut (
        .clk(clk), .reset(reset), .cfg_osr(cfg_osr), .cfg_clr_en(cfg_clr_en),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .alpha(alpha), .dsm_clr(dsm_clr), .dsm_msb(dsm_msb),
        .res_valid(res_valid), .res_ready(res_ready), .res_count(res_count),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // First-order modulator: MSB is the carry of accumulator plus alpha.
    assign dsm_sum = {1'b0, dsm_acc} + {1'b0, alpha};
    assign dsm_msb = use_dsm ? dsm_sum[16] : pat_msb;
    always @(posedge clk or posedge reset) begin
        if (reset)        dsm_acc <= '0;
        else if (dsm_clr) dsm_acc <= '0;
        else              dsm_acc <= dsm_sum[15:0];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge after the result handshake.
    task automatic do_sample(input logic [15:0] data, input logic [9:0] osr,
                             input logic clr, input int bp, output logic [9:0] got);
        int n;
        int exp_cnt;
        n = (osr == 10'd0) ? 1 : int'(osr);
        exp_cnt = 0;
        for (int i = 0; i < n; i++) exp_cnt += pat[i];
        in_valid = 1'b1; in_data = data; cfg_osr = osr; cfg_clr_en = clr;
        chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0; in_data = 16'($urandom);
        cfg_osr = 10'($urandom); cfg_clr_en = 1'($urandom);
        chk("alpha_capture", {16'd0, alpha}, {16'd0, data});
        if (clr) begin
            @(negedge clk);
            chk("clr_pulse", {31'd0, dsm_clr}, 32'd1);
            chk("clr_in_ready", {31'd0, in_ready}, 32'd0);
            @(posedge clk);
        end
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            pat_msb = pat[i][0];
            if (i == n - 1) res_ready = (bp == 0);
            chk("run_no_clr", {31'd0, dsm_clr}, 32'd0);
            chk("run_no_valid", {31'd0, res_valid}, 32'd0);
            if (i == 0) chk("run_busy", {31'd0, busy}, 32'd1);
            @(posedge clk);
        end
        @(negedge clk);
        pat_msb = 1'b0;
        chk("res_valid_up", {31'd0, res_valid}, 32'd1);
        if (!use_dsm) chk("res_count", {22'd0, res_count}, exp_cnt);
        got = res_count;
        for (int b = 0; b < bp; b++) begin
            if (b == 0) begin in_valid = 1'b1; in_data = 16'h1234; end
            @(posedge clk); @(negedge clk);
            chk("bp_valid", {31'd0, res_valid}, 32'd1);
            chk("bp_count", {22'd0, res_count}, {22'd0, got});
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_alpha", {16'd0, alpha}, {16'd0, data});
        end
        res_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("post_valid", {31'd0, res_valid}, 32'd0);
        chk("post_in_ready", {31'd0, in_ready}, 32'd1);
        chk("post_alpha", {16'd0, alpha}, {16'd0, data});
    endtask

    initial begin
        logic [9:0]  got;
        logic [9:0]  cnt [0:3];
        logic [15:0] stream [0:3];
        logic [15:0] rd;
        logic [9:0]  ro;
        int          expr;

        reset = 1'b1; cfg_osr = '0; cfg_clr_en = 1'b0; in_valid = 1'b0;
        in_data = '0; res_ready = 1'b1; pat_msb = 1'b0; use_dsm = 1'b0;
        for (int i = 0; i < 1024; i++) pat[i] = 0;
        repeat (2) @(negedge clk);
        chk("rst_alpha", {16'd0, alpha}, 32'd0);
        chk("rst_valid", {31'd0, res_valid}, 32'd0);
        chk("rst_count", {22'd0, res_count}, 32'd0);
        chk("rst_clr", {31'd0, dsm_clr}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Nominal run: all ones, 16-cycle window, no clear
        for (int i = 0; i < 1024; i++) pat[i] = 1;
        do_sample(16'hFFFF, 10'd16, 1'b0, 0, got);

        // Clear plus alternating MSB starting in RUN
        for (int i = 0; i < 1024; i++) pat[i] = (i % 2 == 0) ? 1 : 0;
        do_sample(16'h5555, 10'd8, 1'b1, 0, got);
        chk("alt_count", {22'd0, got}, 32'd4);

        // Edge windows: osr 0 behaves as 1, osr 1023 does not wrap
        pat[0] = 1;
        do_sample(16'h0101, 10'd0, 1'b0, 0, got);
        pat[0] = 0;
        do_sample(16'h0202, 10'd0, 1'b1, 0, got);
        for (int i = 0; i < 1024; i++) pat[i] = 1;
        do_sample(16'h0303, 10'd1023, 1'b0, 0, got);
        chk("max_count", {22'd0, got}, 32'd1023);

        // Backpressure with the next sample waiting
        for (int i = 0; i < 1024; i++) pat[i] = int'($urandom_range(0, 1));
        do_sample(16'hBEEF, 10'd12, 1'b0, 5, got);
        for (int i = 0; i < 1024; i++) pat[i] = 1;
        do_sample(16'h1234, 10'd3, 1'b0, 0, got);
        chk("bp_next_count", {22'd0, got}, 32'd3);

        // Randomized windows with mid-window config disturbance
        for (int t = 0; t < 12; t++) begin
            for (int i = 0; i < 1024; i++) pat[i] = int'($urandom_range(0, 1));
            rd = 16'($urandom);
            ro = 10'($urandom_range(0, 40));
            do_sample(rd, ro, 1'($urandom), int'($urandom_range(0, 3)), got);
        end

        // Asynchronous reset in the middle of RUN
        for (int i = 0; i < 1024; i++) pat[i] = 1;
        in_valid = 1'b1; in_data = 16'hABCD; cfg_osr = 10'd16; cfg_clr_en = 1'b0;
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("arst_alpha", {16'd0, alpha}, 32'd0);
        chk("arst_valid", {31'd0, res_valid}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_count", {22'd0, res_count}, 32'd0);
        chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        repeat (20) begin
            @(negedge clk);
            chk("arst_no_result", {31'd0, res_valid}, 32'd0);
        end
        do_sample(16'h0F0F, 10'd16, 1'b0, 0, got);
        chk("arst_recover", {22'd0, got}, 32'd16);

        // Back-to-back stream through the modulator model
        stream[0] = 16'h0000; stream[1] = 16'h4000; stream[2] = 16'h8000; stream[3] = 16'hFFFF;
        use_dsm = 1'b1;
        for (int k = 0; k < 4; k++) begin
            do_sample(stream[k], 10'd64, 1'b1, 0, got);
            cnt[k] = got;
            expr = int'((64 * longint'(stream[k]) + 32768) / 65536);
            chk("stream_near", {31'd0, (int'(cnt[k]) >= expr - 1) && (int'(cnt[k]) <= expr + 1)}, 32'd1);
            if (k > 0) chk("stream_mono", {31'd0, cnt[k] >= cnt[k-1]}, 32'd1);
        end
        use_dsm = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dsm_sample_sequencer.md
Name: dsm_sample_sequencer

Overview:
- Sequences the first-order delta-sigma modulator: accepts 16-bit input samples over a valid/ready handshake and drives each one onto the modulator's alpha input for a programmable oversampling window of cfg_osr clocks.
- Optionally pulses a modulator accumulator clear before each window.
- Counts the modulator's MSB ones over the window and returns the count as a per-sample density result over a second valid/ready handshake.
- Sits between the sample source and the dsm core.

Parameters:
- WIDTH, 16, sample/alpha width.
- OSR_W, 10, width of cfg_osr and res_count. Max window is 2^OSR_W-1 cycles.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- cfg_osr  in  OSR_W  window length in cycles. Sampled at capture; 0 is treated as 1.
- cfg_clr_en  in  1  when 1, insert a one-cycle dsm_clr before each window. Sampled at capture.
- in_valid  in  1  input sample valid.
- in_ready  out  1  sequencer can accept a sample.
- in_data  in  WIDTH  input sample.
- alpha  out  WIDTH  to dsm alpha input.
- dsm_clr  out  1  synchronous clear pulse to dsm accumulator.
- dsm_msb  in  1  dsm MSB output.
- res_valid  out  1  result valid.
- res_ready  in  1  result consumer ready.
- res_count  out  OSR_W  number of dsm_msb==1 cycles in the window.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, immediate):
  - state=IDLE; alpha=0; dsm_clr=0; res_valid=0; res_count=0.
  - Internal cycle and ones counters = 0.
  - Any in-flight window or pending result is discarded.
- States: IDLE, CLEAR, RUN, REPORT.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid&in_ready:
    - alpha<=in_data.
    - osr_q<=(cfg_osr==0 ? 1 : cfg_osr).
    - clr_q<=cfg_clr_en.
    - ones<=0; cyc<=0.
    - Next state is CLEAR if cfg_clr_en, else RUN.
- CLEAR:
  - Exactly one cycle; dsm_clr=1 (combinational from state); in_ready=0.
  - Next state is RUN.
  - dsm_msb is ignored in this state.
- RUN:
  - On every edge: ones<=ones+dsm_msb; cyc<=cyc+1.
  - When cyc==osr_q-1 on that edge: res_count<=ones+dsm_msb, state<=REPORT.
  - Exactly osr_q edges are counted.
- REPORT:
  - res_valid=1.
  - res_count is held stable until the edge with res_ready=1, then state goes to IDLE.
  - in_ready=0 throughout; the next sample is accepted no earlier than the cycle after the handshake.
- alpha:
  - Holds the last captured sample in all states, including IDLE and REPORT, so the modulator keeps running.
  - Changes only on a capture edge or on reset.
- Latency, with capture on edge E0:
  - Without clear: RUN covers edges E1..E(osr_q); res_valid is high after edge E(osr_q).
  - With clear: dsm_clr is high between E0 and E1; RUN covers E2..E(osr_q+1).
- Widths: ones ≤ osr_q ≤ 2^OSR_W-1, so no overflow and no saturation logic.
- cfg_osr and cfg_clr_en changes mid-window have no effect until the next capture.
- busy = (state != IDLE).
- No combinational path from in_valid to in_ready, or from res_ready to res_valid.

Test Plan:
- Nominal run:
  - Stimulus: dsm_msb tied 1, cfg_osr=16, cfg_clr_en=0, in_data=16'hFFFF, res_ready=1.
  - Response: alpha=16'hFFFF after capture; res_valid high 16 cycles after capture; res_count=16; dsm_clr never asserted.
- Clear and alternating MSB:
  - Stimulus: cfg_clr_en=1, cfg_osr=8, bench drives dsm_msb alternating 1,0 starting in RUN.
  - Response: dsm_clr high exactly 1 cycle, right after capture; res_count=4; res_valid high 9 cycles after capture.
- Edge window lengths:
  - Stimulus: cfg_osr=0, then cfg_osr=1023 with dsm_msb=1.
  - Response: 0 gives a 1-cycle window with res_count=dsm_msb; 1023 gives res_count=1023 with no wrap.
- Backpressure:
  - Stimulus: res_ready=0 for 5 cycles after res_valid rises; in_valid held high with in_data=16'h1234.
  - Response: res_count stable and in_ready=0 for all 5 cycles. 16'h1234 is captured only in the IDLE cycle after the res handshake. alpha keeps the old sample until then.
- Reset mid-RUN:
  - Stimulus: reset asserted at cycle 5 of a 16-cycle window, asynchronous to clk.
  - Response: immediate return to state=IDLE, alpha=0, res_valid=0, busy=0; no result is emitted. After reset release, a new sample completes normally.
- Back-to-back stream:
  - Stimulus: 4 samples {0x0000, 0x4000, 0x8000, 0xFFFF} with cfg_osr=64, driven through the dsm core.
  - Response: 4 results in order; counts are nondecreasing and within ±1 of round(alpha*64/65536).
